// File: rtl/alu_operand_fetch.sv
// ---------------------------------------------------------------------------
// alu_operand_fetch
//   Operand fetch stage in front of the ALU. It takes a 6502 group-01 opcode
//   with its operand bytes and computes the effective address. When the mode
//   needs memory data it reads one byte over a req/ack handshake. It then
//   issues a single-cycle ALU command. Non-ALU or unsupported opcodes are
//   rejected with an illegal pulse. A stalled read is abandoned with bus_err.
//
// Parameters
//   ZP_BASE  base address OR'd onto zero-page effective addresses
//   TIMEOUT  MEM cycles to wait for mem_ack before bus_err (0 = wait forever)
//
// Optional build macro
//   PAGE_CROSS_PENALTY_EN  adds a FIX cycle on abs,X/Y page crossings. During
//                          FIX, mem_addr shows the uncorrected {op_hi, ea[7:0]}.
//
// Ports
//   clk, rst (asynchronous, active low)
//   instr_valid/instr_ready      instruction handshake (ready only in IDLE)
//   opcode, op_lo, op_hi         opcode byte and operand bytes
//   idx_x, idx_y                 index registers
//   mem_req/mem_addr/mem_rdata/mem_ack  byte read interface
//   alu_valid, alu_op, alu_operand, page_cross   ALU issue
//   illegal, bus_err             one-cycle error pulses
// ---------------------------------------------------------------------------
module alu_operand_fetch #(
    parameter logic [15:0] ZP_BASE = 16'h0000,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [7:0]  opcode,
    input  logic [7:0]  op_lo,
    input  logic [7:0]  op_hi,
    input  logic [7:0]  idx_x,
    input  logic [7:0]  idx_y,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        alu_valid,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_operand,
    output logic        page_cross,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_FIX,
        S_MEM,
        S_ISSUE,
        S_ERR
    } state_t;

    localparam logic [2:0]  MODE_ZP   = 3'b001;
    localparam logic [2:0]  MODE_IMM  = 3'b010;
    localparam logic [2:0]  MODE_ABS  = 3'b011;
    localparam logic [2:0]  MODE_ZPX  = 3'b101;
    localparam logic [2:0]  MODE_ABSY = 3'b110;
    localparam logic [2:0]  MODE_ABSX = 3'b111;
    localparam logic [15:0] TO_LAST   = (TIMEOUT != 0) ? 16'(TIMEOUT - 1) : 16'h0000;

    // Legal means: group 01, not STA/LDA, and not an indirect mode.
    function automatic logic is_legal(input logic [7:0] opc);
        logic ok;
        ok = (opc[1:0] == 2'b01);
        if (opc[7:5] == 3'b100 || opc[7:5] == 3'b101) ok = 1'b0;
        if (opc[4:2] == 3'b000 || opc[4:2] == 3'b100) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [3:0] map_op(input logic [2:0] aaa);
        logic [3:0] op;
        case (aaa)
            3'b000:  op = 4'd3;   // ORA
            3'b001:  op = 4'd2;   // AND
            3'b010:  op = 4'd4;   // EOR
            3'b011:  op = 4'd0;   // ADC
            3'b110:  op = 4'd5;   // CMP
            3'b111:  op = 4'd1;   // SBC
            default: op = 4'd0;
        endcase
        return op;
    endfunction

    state_t      state_reg, state_next;
    logic [7:0]  opcode_reg, lo_reg, hi_reg, x_reg, y_reg;
    logic [7:0]  operand_reg;
    logic [15:0] mem_addr_reg;
    logic [15:0] to_cnt_reg;
    logic        bus_flag_reg;
    logic [3:0]  last_op_reg;
    logic [7:0]  last_operand_reg;

    logic [2:0]  mode;
    logic [7:0]  zpx_sum;
    logic [15:0] abs_addr;
    logic [15:0] ea;
    logic        page_cross_c;
    logic [3:0]  op_c;
    logic        timed_out;

    // Effective address from the latched instruction. These registers stay
    // stable for the whole transaction, so ea can be combinational.
    assign mode     = opcode_reg[4:2];
    assign zpx_sum  = lo_reg + x_reg;          // wraps within the zero page
    assign abs_addr = {hi_reg, lo_reg};
    assign op_c     = map_op(opcode_reg[7:5]);

    always_comb begin
        ea = abs_addr;
        case (mode)
            MODE_ZP:   ea = ZP_BASE | {8'h00, lo_reg};
            MODE_ZPX:  ea = ZP_BASE | {8'h00, zpx_sum};
            MODE_ABS:  ea = abs_addr;
            MODE_ABSY: ea = abs_addr + {8'h00, y_reg};
            MODE_ABSX: ea = abs_addr + {8'h00, x_reg};
            default:   ea = abs_addr;
        endcase
    end

    assign page_cross_c = ((mode == MODE_ABSX) || (mode == MODE_ABSY)) &&
                          (ea[15:8] != hi_reg);

    assign timed_out = (TIMEOUT != 0) && (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (instr_valid) begin
                    if (!is_legal(opcode))
                        state_next = S_ERR;
                    else if (opcode[4:2] == MODE_IMM)
                        state_next = S_ISSUE;
                    else
                        state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                state_next = S_MEM;
`ifdef PAGE_CROSS_PENALTY_EN
                if (page_cross_c) state_next = S_FIX;
`endif
            end
            S_FIX:   state_next = S_MEM;
            S_MEM: begin
                if (mem_ack)
                    state_next = S_ISSUE;
                else if (timed_out)
                    state_next = S_ERR;
            end
            S_ISSUE: state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg        <= S_IDLE;
            opcode_reg       <= 8'h00;
            lo_reg           <= 8'h00;
            hi_reg           <= 8'h00;
            x_reg            <= 8'h00;
            y_reg            <= 8'h00;
            operand_reg      <= 8'h00;
            mem_addr_reg     <= 16'h0000;
            to_cnt_reg       <= 16'h0000;
            bus_flag_reg     <= 1'b0;
            last_op_reg      <= 4'h0;
            last_operand_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (instr_valid) begin
                        opcode_reg   <= opcode;
                        lo_reg       <= op_lo;
                        hi_reg       <= op_hi;
                        x_reg        <= idx_x;
                        y_reg        <= idx_y;
                        operand_reg  <= op_lo;   // immediate operand; replaced by read data otherwise
                        bus_flag_reg <= 1'b0;
                    end
                end
                S_ADDR: begin
                    to_cnt_reg   <= 16'h0000;
`ifdef PAGE_CROSS_PENALTY_EN
                    // The FIX cycle exposes the uncarried address first.
                    mem_addr_reg <= page_cross_c ? {hi_reg, ea[7:0]} : ea;
`else
                    mem_addr_reg <= ea;
`endif
                end
                S_FIX: begin
                    to_cnt_reg   <= 16'h0000;
                    mem_addr_reg <= ea;
                end
                S_MEM: begin
                    if (mem_ack)
                        operand_reg <= mem_rdata;
                    else if (timed_out)
                        bus_flag_reg <= 1'b1;
                    else
                        to_cnt_reg <= to_cnt_reg + 16'd1;
                end
                S_ISSUE: begin
                    last_op_reg      <= op_c;
                    last_operand_reg <= operand_reg;
                end
                default: ;
            endcase
        end
    end

    // ALU outputs show the live command during ISSUE. At all other times they
    // show the last issued command, so the ALU sees stable values between strobes.
    assign instr_ready = (state_reg == S_IDLE);
    assign mem_req     = (state_reg == S_MEM);
    assign mem_addr    = mem_addr_reg;
    assign alu_valid   = (state_reg == S_ISSUE);
    assign alu_op      = alu_valid ? op_c : last_op_reg;
    assign alu_operand = alu_valid ? operand_reg : last_operand_reg;
    assign page_cross  = alu_valid && page_cross_c;
    assign illegal     = (state_reg == S_ERR) && !bus_flag_reg;
    assign bus_err     = (state_reg == S_ERR) && bus_flag_reg;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_fetch
//   Drives directed and randomized instructions into alu_operand_fetch and
//   acts as the memory responder. Every observed cycle and value is compared
//   against expectations computed from the addressing/decode rules.
// ---------------------------------------------------------------------------
module tb_alu_operand_fetch;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  opcode = 8'h00, op_lo = 8'h00, op_hi = 8'h00;
    logic [7:0]  idx_x = 8'h00, idx_y = 8'h00;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        alu_valid;
    logic [3:0]  alu_op;
    logic [7:0]  alu_operand;
    logic        page_cross;
    logic        illegal;
    logic        bus_err;

    int checks = 0;
    int failures = 0;
    int last_op = 0;
    int last_operand = 0;
`ifdef PAGE_CROSS_PENALTY_EN
    localparam int PENALTY = 1;
`else
    localparam int PENALTY = 0;
`endif

    alu_operand_fetch #(.ZP_BASE(16'h0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .op_lo(op_lo), .op_hi(op_hi),
        .idx_x(idx_x), .idx_y(idx_y),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_valid(alu_valid), .alu_op(alu_op), .alu_operand(alu_operand),
        .page_cross(page_cross), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction, start to finish. Entered and left just after a
    // negedge. ack_delay is the number of MEM cycles without ack before ack
    // arrives. A value >= TO never acks.
    task automatic run(input logic [7:0] opc, input logic [7:0] lo, input logic [7:0] hi,
                       input logic [7:0] x, input logic [7:0] y,
                       input int ack_delay, input logic [7:0] rdata, input bit noise);
        int aaa, bbb, ea, exp_op, exp_first;
        bit legal, imm, pc, done;
        int cyc, req_cnt, first_req, ack_cyc, av_cyc, ill_cyc, be_cyc;
        int got_op, got_operand, got_pc;
        int op_tab[8] = '{3, 2, 4, 0, -1, -1, 5, 1};

        aaa = int'(opc[7:5]);
        bbb = int'(opc[4:2]);
        legal = (opc[1:0] == 2'b01) && aaa != 4 && aaa != 5 && bbb != 0 && bbb != 4;
        imm = (bbb == 2);
        exp_op = op_tab[aaa];
        case (bbb)
            1: ea = int'(lo);
            5: ea = (int'(lo) + int'(x)) % 256;
            3: ea = int'(hi) * 256 + int'(lo);
            6: ea = (int'(hi) * 256 + int'(lo) + int'(y)) % 65536;
            7: ea = (int'(hi) * 256 + int'(lo) + int'(x)) % 65536;
            default: ea = 0;
        endcase
        pc = (bbb == 6 || bbb == 7) && ((ea / 256) != int'(hi));
        exp_first = 2 + ((PENALTY != 0 && pc) ? 1 : 0);

        chk("ready_before", instr_ready, 1);
        opcode = opc; op_lo = lo; op_hi = hi; idx_x = x; idx_y = y;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        opcode = 8'($urandom); op_lo = 8'($urandom); op_hi = 8'($urandom);
        idx_x = 8'($urandom); idx_y = 8'($urandom);

        cyc = 1; req_cnt = 0; first_req = -1; ack_cyc = -1;
        av_cyc = -1; ill_cyc = -1; be_cyc = -1; done = 0;
        got_op = 0; got_operand = 0; got_pc = 0;
        while (!done && cyc < 40) begin
            if (PENALTY != 0 && legal && pc && cyc == 2) begin
                chk("fix_addr", mem_addr, 32'(int'(hi) * 256 + (ea % 256)));
                chk("fix_noreq", mem_req, 0);
            end
            mem_rdata = 8'($urandom);
            if (mem_req) begin
                req_cnt++;
                if (first_req < 0) first_req = cyc;
                chk("mem_addr", mem_addr, 32'(ea));
                if (req_cnt == ack_delay + 1) begin
                    mem_ack = 1'b1; mem_rdata = rdata; ack_cyc = cyc;
                end else begin
                    mem_ack = 1'b0;
                end
            end else begin
                mem_ack = noise;
            end
            if (alu_valid) begin
                av_cyc = cyc; got_op = int'(alu_op); got_operand = int'(alu_operand);
                got_pc = int'(page_cross); done = 1;
            end
            if (illegal) begin ill_cyc = cyc; done = 1; end
            if (bus_err) begin be_cyc = cyc; done = 1; end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("end_seen", done, 1);

        if (!legal) begin
            chk("ill_cycle", ill_cyc, 1);
            chk("ill_noreq", req_cnt, 0);
            chk("ill_noalu", av_cyc, -1);
        end else if (imm) begin
            chk("imm_cycle", av_cyc, 1);
            chk("imm_noreq", req_cnt, 0);
        end else if (ack_delay >= TO) begin
            chk("to_first_req", first_req, exp_first);
            chk("to_buserr_cycle", be_cyc, exp_first + TO);
            chk("to_noalu", av_cyc, -1);
        end else begin
            chk("first_req", first_req, exp_first);
            chk("alu_cycle", av_cyc, exp_first + ack_delay + 1);
            chk("req_cycles", req_cnt, ack_delay + 1);
        end
        if (legal && !(ack_delay >= TO && !imm)) begin
            chk("alu_op", got_op, exp_op);
            chk("alu_operand", got_operand, imm ? int'(lo) : int'(rdata));
            chk("page_cross", got_pc, int'(pc));
            last_op = exp_op;
            last_operand = imm ? int'(lo) : int'(rdata);
        end

        mem_ack = 1'b0;
        @(negedge clk);
        chk("ready_after", instr_ready, 1);
        chk("req_after", mem_req, 0);
        chk("hold_op", alu_op, 32'(last_op));
        chk("hold_operand", alu_operand, 32'(last_operand));
        $display("txn opc=%02h lo=%02h hi=%02h x=%02h y=%02h delay=%0d legal=%0d ea=%04h pc=%0d",
                 opc, lo, hi, x, y, ack_delay, legal, ea, pc);
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_page_cross", page_cross, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_operand", alu_operand, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);

        // Directed steps
        run(8'h69, 8'h42, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);   // ADC #
        run(8'h25, 8'h80, 8'h00, 8'h00, 8'h00, 3, 8'h5A, 0);   // AND zp
        run(8'h15, 8'hF0, 8'h00, 8'h20, 8'h00, 1, 8'hC3, 1);   // ORA zp,X wrap
        run(8'h7D, 8'hF0, 8'h12, 8'h20, 8'h00, 0, 8'h77, 0);   // ADC abs,X cross
        run(8'h85, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1);   // STA zp
        run(8'h61, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);   // ADC (zp,X)
        run(8'hD9, 8'h34, 8'h12, 8'h00, 8'h05, 2, 8'h99, 0);   // CMP abs,Y no cross
        run(8'h4D, 8'hCD, 8'hAB, 8'h00, 8'h00, 0, 8'h11, 1);   // EOR abs
        run(8'hE5, 8'h44, 8'h00, 8'h00, 8'h00, 100, 8'h00, 0); // SBC zp, timeout
        run(8'hE5, 8'h44, 8'h00, 8'h00, 8'h00, TO - 1, 8'hE1, 0); // ack in last MEM cycle
        run(8'hF9, 8'hFF, 8'hFF, 8'h00, 8'h01, 0, 8'h3C, 0);   // SBC abs,Y wraps to 0000

        // Randomized steps
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ro;
            ro = 8'($urandom);
            if ($urandom_range(0, 9) < 8) ro[1:0] = 2'b01;
            run(ro, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, TO + 1)), 8'($urandom), 1'($urandom));
        end

        // Reset in the middle of a memory read
        run(8'h09, 8'h5C, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);   // leaves a nonzero alu_operand
        opcode = 8'hE5; op_lo = 8'h33; instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_req_seen", mem_req, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_alu_valid", alu_valid, 0);
        chk("midrst_alu_op", alu_op, 0);
        chk("midrst_alu_operand", alu_operand, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        last_op = 0;
        last_operand = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", instr_ready, 1);
        chk("midrst_no_req", mem_req, 0);
        $display("txn mid-MEM reset opc=e5 lo=33");
        run(8'h29, 8'h0F, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);   // AND # after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
